shamt_detector: RTL and testbench

//  Inverse of the combinational shifter: given an original word and an observed
//  (shifted/rotated) word, searches sequentially for the smallest shift amount

---
 rtl/shamt_detector_pkg.sv | 14 +
 rtl/shamt_detector_shifter.sv | 51 +++++
 rtl/shamt_detector.sv | 139 +++++++++++++
 tb/tb_shamt_detector.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shamt_detector_pkg.sv
//------------------------------------------------------------------------------
// shamt_detector_pkg
//   Shared enable and polarity constants for the shift-amount detector slice.
//   ENABLE/DISABLE select a feature.
//   HIGH/LOW give the active level of a flag output.
//------------------------------------------------------------------------------
package shamt_detector_pkg;

   localparam bit ENABLE  = 1'b1;
   localparam bit DISABLE = 1'b0;
   localparam bit HIGH    = 1'b1;
   localparam bit LOW     = 1'b0;

endpackage : shamt_detector_pkg

// File: rtl/shamt_detector_shifter.sv
//------------------------------------------------------------------------------
// shamt_detector_shifter
//   Combinational shifter. It applies a shift or rotate of `shamt` positions to
//   `in`.
// Parameters
//   ROTATE    1: rotate.  0: logical shift with zero fill.
//   TO_RIGHT  1: shift right.  0: shift left.
//   DATA      data word width.
//   SHAMT     shift-amount width.
// Ports
//   in     in   DATA   word to shift
//   shamt  in   SHAMT  shift amount
//   out    out  DATA   shifted or rotated word
//------------------------------------------------------------------------------
module shamt_detector_shifter #(
   parameter bit ROTATE   = 1'b1,
   parameter bit TO_RIGHT = 1'b0,
   parameter int DATA     = 8,
   parameter int SHAMT    = 3
) (
   input  logic [DATA-1:0]  in,
   input  logic [SHAMT-1:0] shamt,
   output logic [DATA-1:0]  out
);

   if (ROTATE) begin : g_rotate
      // A rotate by an amount of DATA or more is the same as a rotate by the
      // amount modulo DATA. Shifting a doubled copy of the word gives the rotate.
      logic [2*DATA-1:0] dbl;
      int unsigned       rot_amt;

      always_comb begin
         rot_amt = 32'(shamt) % 32'(DATA);
         if (TO_RIGHT) begin
            dbl = {in, in} >> rot_amt;
            out = dbl[DATA-1:0];
         end else begin
            dbl = {in, in} << rot_amt;
            out = dbl[2*DATA-1 -: DATA];
         end
      end
   end else begin : g_shift
      // A shift by DATA or more positions gives all zeros.
      if (TO_RIGHT) begin : g_right
         assign out = in >> shamt;
      end else begin : g_left
         assign out = in << shamt;
      end
   end

endmodule : shamt_detector_shifter

// File: rtl/shamt_detector.sv
//------------------------------------------------------------------------------
// shamt_detector
//   This block is the inverse of the shifter. It takes an original word and an
//   observed word. It then tries candidate shift amounts, one per cycle, starting
//   from 0. It reports the first candidate that maps the original word onto the
//   observed word. Both the request side and the result side use valid/ready
//   handshakes.
// Parameters
//   ROTATE    ENABLE: rotate semantics.  DISABLE: logical shift, zero fill.
//   TO_RIGHT  ENABLE: candidates are right shifts.  DISABLE: left shifts.
//   DATA      data word width.
//   SHAMT     shift-amount width. The search space is 0 .. 2^SHAMT-1.
//   ACT       active level of res_found.
// Ports
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous reset, active-high
//   clear      in   1      synchronous abort back to IDLE
//   req_valid  in   1      request valid
//   req_ready  out  1      high only in IDLE
//   ref_data   in   DATA   original (unshifted) word
//   obs_data   in   DATA   observed (shifted) word
//   res_valid  out  1      result valid, high only in DONE
//   res_ready  in   1      result consumed
//   res_shamt  out  SHAMT  smallest matching shift amount, 0 if none
//   res_found  out  1      ACT when a match exists
//------------------------------------------------------------------------------
module shamt_detector
   import shamt_detector_pkg::*;
#(
   parameter bit ROTATE   = ENABLE,
   parameter bit TO_RIGHT = DISABLE,
   parameter int DATA     = 8,
   parameter int SHAMT    = 3,
   parameter bit ACT      = HIGH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [DATA-1:0]  ref_data,
   input  logic [DATA-1:0]  obs_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [SHAMT-1:0] res_shamt,
   output logic             res_found
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [SHAMT-1:0] CAND_MAX = '1;

   state_t           state;
   logic [SHAMT-1:0] cand;
   logic [DATA-1:0]  ref_q;
   logic [DATA-1:0]  obs_q;
   logic [DATA-1:0]  shifted;
   logic             match;

   shamt_detector_shifter #(
      .ROTATE   (ROTATE),
      .TO_RIGHT (TO_RIGHT),
      .DATA     (DATA),
      .SHAMT    (SHAMT)
   ) u_shifter (
      .in    (ref_q),
      .shamt (cand),
      .out   (shifted)
   );

   assign match = (shifted == obs_q);

   // The handshake outputs come only from the state register. This way there is
   // no combinational path from any input to req_ready or res_valid.
   assign req_ready = (state == IDLE);
   assign res_valid = (state == DONE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge. Blocking assignments here would
   // make the result depend on statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the captured operand registers are reset as well, even though
         // they are never read before they are written. This keeps their
         // contents deterministic after reset.
         state     <= IDLE;
         cand      <= '0;
         ref_q     <= '0;
         obs_q     <= '0;
         res_shamt <= '0;
         res_found <= ~ACT;
      end else if (clear) begin
         // clear overrides a same-edge accept or result handshake.
         state     <= IDLE;
         cand      <= '0;
         res_shamt <= '0;
         res_found <= ~ACT;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  ref_q <= ref_data;
                  obs_q <= obs_data;
                  cand  <= '0;
                  state <= SEARCH;
               end
            end
            SEARCH: begin
               // Candidates are tried in ascending order, so the first hit is
               // the smallest matching shift amount.
               if (match) begin
                  res_shamt <= cand;
                  res_found <= ACT;
                  state     <= DONE;
               end else if (cand == CAND_MAX) begin
                  res_shamt <= '0;
                  res_found <= ~ACT;
                  state     <= DONE;
               end else begin
                  cand <= cand + 1'b1;
               end
            end
            DONE: begin
               if (res_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : shamt_detector

// File: tb/tb_shamt_detector.sv
//------------------------------------------------------------------------------
// tb_shamt_detector
//   This bench has two instances that share their inputs.
//     u_rot    ROTATE=1, left.
//     u_shift  ROTATE=0, left.
//   A behavioural model predicts each instance from the search rules:
//     - the smallest k whose shift of ref gives obs,
//     - latency k+1, or 2^SHAMT cycles when there is no match.
//   One compare process checks the handshake outputs and the results against
//   the model on every falling edge. Directed cases pin the model to
//   hand-computed literals.
//------------------------------------------------------------------------------
module tb_shamt_detector;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clear = 1'b0;
   logic       req_valid = 1'b0;
   logic       res_ready = 1'b0;
   logic [7:0] ref_data = 8'h00;
   logic [7:0] obs_data = 8'h00;

   logic [1:0] req_ready_w;
   logic [1:0] res_valid_w;
   logic [2:0] res_shamt_w [2];
   logic [1:0] res_found_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shamt_detector #(.ROTATE(1'b1), .TO_RIGHT(1'b0), .DATA(8), .SHAMT(3), .ACT(1'b1)) u_rot (
      .clk(clk), .reset(reset), .clear(clear),
      .req_valid(req_valid), .req_ready(req_ready_w[0]),
      .ref_data(ref_data), .obs_data(obs_data),
      .res_valid(res_valid_w[0]), .res_ready(res_ready),
      .res_shamt(res_shamt_w[0]), .res_found(res_found_w[0])
   );

   shamt_detector #(.ROTATE(1'b0), .TO_RIGHT(1'b0), .DATA(8), .SHAMT(3), .ACT(1'b1)) u_shift (
      .clk(clk), .reset(reset), .clear(clear),
      .req_valid(req_valid), .req_ready(req_ready_w[1]),
      .ref_data(ref_data), .obs_data(obs_data),
      .res_valid(res_valid_w[1]), .res_ready(res_ready),
      .res_shamt(res_shamt_w[1]), .res_found(res_found_w[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Left shift or left rotate of an 8-bit word, computed with integer arithmetic.
   function automatic logic [7:0] shift_word(input logic [7:0] r, input int k, input bit rot);
      int v;
      int m;
      v = int'(r);
      if (rot) begin
         m = k % 8;
         return 8'(((v << m) | (v >> (8 - m))) & 255);
      end
      return 8'((v << k) & 255);
   endfunction

   // ---------------- behavioural model ----------------
   bit         m_idle  [2] = '{1'b1, 1'b1};
   bit         m_valid [2] = '{1'b0, 1'b0};
   int         m_rem   [2] = '{0, 0};
   logic [2:0] m_sh    [2] = '{3'd0, 3'd0};
   logic       m_f     [2] = '{1'b0, 1'b0};
   logic [2:0] p_sh    [2];
   logic       p_f     [2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset || clear) begin
            m_idle[i] = 1'b1; m_valid[i] = 1'b0; m_rem[i] = 0;
            m_sh[i] = 3'd0; m_f[i] = 1'b0;
         end else if (m_idle[i]) begin
            if (req_valid) begin
               p_sh[i] = 3'd0; p_f[i] = 1'b0; m_rem[i] = 8;
               for (int k = 7; k >= 0; k--) begin
                  if (shift_word(ref_data, k, (i == 0)) == obs_data) begin
                     p_sh[i] = 3'(k); p_f[i] = 1'b1; m_rem[i] = k + 1;
                  end
               end
               m_idle[i] = 1'b0;
            end
         end else if (m_rem[i] > 0) begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin
               m_valid[i] = 1'b1; m_sh[i] = p_sh[i]; m_f[i] = p_f[i];
            end
         end else if (m_valid[i] && res_ready) begin
            m_valid[i] = 1'b0; m_idle[i] = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            check($sformatf("req_ready[%0d]", i), 32'(req_ready_w[i]), 32'(m_idle[i]));
            check($sformatf("res_valid[%0d]", i), 32'(res_valid_w[i]), 32'(m_valid[i]));
            if (m_valid[i]) begin
               check($sformatf("res_shamt[%0d]", i), 32'(res_shamt_w[i]), 32'(m_sh[i]));
               check($sformatf("res_found[%0d]", i), 32'(res_found_w[i]), 32'(m_f[i]));
            end
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_idle();
      int n = 0;
      res_ready = 1'b1;
      while (!(&req_ready_w) && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      check("idle_timeout", 32'(n < 50), 32'd1);
      res_ready = 1'b0;
   endtask

   task automatic run_case(input string nm, input logic [7:0] r, input logic [7:0] o,
                           input int which, input int exp_lat, input logic [2:0] exp_sh,
                           input logic exp_f, input int hold);
      int n = 0;
      wait_idle();
      req_valid = 1'b1; ref_data = r; obs_data = o; res_ready = 1'b0;
      @(negedge clk); #1;
      req_valid = 1'b0;
      while (!res_valid_w[which] && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      check({nm, "_latency"}, 32'(n), 32'(exp_lat));
      check({nm, "_shamt"}, 32'(res_shamt_w[which]), 32'(exp_sh));
      check({nm, "_found"}, 32'(res_found_w[which]), 32'(exp_f));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk); #1;
         check({nm, "_hold_valid"}, 32'(res_valid_w[which]), 32'd1);
         check({nm, "_hold_ready"}, 32'(req_ready_w[which]), 32'd0);
         check({nm, "_hold_shamt"}, 32'(res_shamt_w[which]), 32'(exp_sh));
      end
      res_ready = 1'b1;
      @(negedge clk); #1;
      res_ready = 1'b0;
      check({nm, "_ready_after"}, 32'(req_ready_w[which]), 32'd1);
      check({nm, "_valid_after"}, 32'(res_valid_w[which]), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int k;
      @(negedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         check("rst_req_ready", 32'(req_ready_w[i]), 32'd1);
         check("rst_res_valid", 32'(res_valid_w[i]), 32'd0);
         check("rst_res_shamt", 32'(res_shamt_w[i]), 32'd0);
         check("rst_res_found", 32'(res_found_w[i]), 32'd0);
      end
      @(negedge clk); #1;
      reset = 1'b0;

      run_case("c1_rot",    8'b10011100, 8'b01110010, 0, 3, 3'd2, 1'b1, 5);
      run_case("c2_equal",  8'b10011100, 8'b10011100, 0, 1, 3'd0, 1'b1, 0);
      run_case("c3_none",   8'b10011100, 8'hFF,       0, 8, 3'd0, 1'b0, 0);
      run_case("c4_period", 8'hAA,       8'h55,       0, 2, 3'd1, 1'b1, 0);
      run_case("c6_zero",   8'h9C,       8'h00,       1, 7, 3'd6, 1'b1, 0);
      run_case("c6_rotnz",  8'h9C,       8'h00,       0, 8, 3'd0, 1'b0, 0);

      // Reset in the middle of a search.
      wait_idle();
      req_valid = 1'b1; ref_data = 8'h9C; obs_data = 8'hFF;
      @(negedge clk); #1;
      req_valid = 1'b0;
      repeat (2) begin @(negedge clk); #1; end
      check("search_busy", 32'(req_ready_w[0]), 32'd0);
      reset = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         check("midrst_req_ready", 32'(req_ready_w[i]), 32'd1);
         check("midrst_res_valid", 32'(res_valid_w[i]), 32'd0);
         check("midrst_res_shamt", 32'(res_shamt_w[i]), 32'd0);
         check("midrst_res_found", 32'(res_found_w[i]), 32'd0);
      end
      @(negedge clk); #1;
      reset = 1'b0;

      // clear together with req_valid: the request must not be accepted.
      clear = 1'b1; req_valid = 1'b1; ref_data = 8'h12; obs_data = 8'h12;
      @(negedge clk); #1;
      clear = 1'b0; req_valid = 1'b0;
      check("clr_acc_ready", 32'(req_ready_w[0]), 32'd1);
      @(negedge clk); #1;
      check("clr_acc_ready2", 32'(req_ready_w[1]), 32'd1);

      // clear in DONE drops the result back to its reset values.
      req_valid = 1'b1; ref_data = 8'b10011100; obs_data = 8'b01110010;
      @(negedge clk); #1;
      req_valid = 1'b0;
      repeat (3) begin @(negedge clk); #1; end
      check("pre_clr_valid", 32'(res_valid_w[0]), 32'd1);
      clear = 1'b1;
      @(negedge clk); #1;
      clear = 1'b0;
      check("clr_done_valid", 32'(res_valid_w[0]), 32'd0);
      check("clr_done_shamt", 32'(res_shamt_w[0]), 32'd0);
      check("clr_done_found", 32'(res_found_w[0]), 32'd0);
      check("clr_done_ready", 32'(req_ready_w[0]), 32'd1);

      // Randomized traffic: the model and the compare process do the checking.
      repeat (3000) begin
         @(negedge clk); #1;
         reset     = ($urandom_range(0, 399) == 0);
         clear     = ($urandom_range(0, 59) == 0);
         req_valid = ($urandom_range(0, 2) != 0);
         res_ready = ($urandom_range(0, 3) != 0);
         ref_data  = 8'($urandom);
         k = int'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       obs_data = 8'($urandom);
            1:       obs_data = shift_word(ref_data, k, 1'b1);
            2:       obs_data = shift_word(ref_data, k, 1'b0);
            default: obs_data = ref_data;
         endcase
      end
      reset = 1'b0; clear = 1'b0; req_valid = 1'b0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_shamt_detector
